// File: rtl/flash_qspi_controller_if.sv
// Cache-side page-fill handshake between the flash cache (master) and
// flash_qspi_controller (slave).
interface flash_qspi_controller_if;
  logic        qspi_enable;
  logic [23:0] qspi_address;
  logic        qspi_changeAddress;
  logic        qspi_requestData;
  logic [31:0] qspi_readData;
  logic        qspi_readDataValid;
  logic        qspi_initialised;
  logic        qspi_busy;

  modport master (
    output qspi_enable, qspi_address, qspi_changeAddress, qspi_requestData,
    input  qspi_readData, qspi_readDataValid, qspi_initialised, qspi_busy
  );

  modport slave (
    input  qspi_enable, qspi_address, qspi_changeAddress, qspi_requestData,
    output qspi_readData, qspi_readDataValid, qspi_initialised, qspi_busy
  );
endinterface

// File: rtl/flash_qspi_controller.sv
// SPI/QSPI NOR flash responder for cache page fills: release-from-power-down, then
// sequential little-endian 32-bit word reads. Define FLASH_QSPI_QUAD_EN for quad output reads.
module flash_qspi_controller #(
  parameter int unsigned INIT_DELAY   = 16,
  parameter int unsigned RESUME_DELAY = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  flash_qspi_controller_if.slave        qspi,
  output logic                          flash_csb,
  output logic                          flash_sck,
  output logic [3:0]                    flash_io_we,
  output logic [3:0]                    flash_io_out,
  input  logic [3:0]                    flash_io_in
);

`ifdef FLASH_QSPI_QUAD_EN
  localparam logic [7:0] READ_CMD  = 8'h6B;
  localparam logic [5:0] LAST_DATA = 6'd7;
  localparam logic [3:0] DATA_WE   = 4'b0000;
`else
  localparam logic [7:0] READ_CMD  = 8'h03;
  localparam logic [5:0] LAST_DATA = 6'd31;
  localparam logic [3:0] DATA_WE   = 4'b0001;
`endif
  localparam logic [7:0] RELEASE_CMD = 8'hAB;

  typedef enum logic [3:0] {
    RESET_WAIT, INIT_CMD, INIT_WAIT, IDLE, CMD, ADDR, DUMMY, DATA, PAUSE
  } state_t;

  state_t      state;
  logic        phase;
  logic [5:0]  bitCnt;
  logic [15:0] waitCnt;
  logic [31:0] txShift;
  logic [31:0] rxWord;
  logic [31:0] rxNext;
  logic        pending;
  logic [23:0] pendAddr;
  logic        csb;
  logic        sck;
  logic [3:0]  ioWe;
  logic [3:0]  ioOut;
  logic [31:0] readData;
  logic        readDataValid;
  logic        initialised;
  logic [23:0] startAddr;

  assign flash_csb               = csb;
  assign flash_sck               = sck;
  assign flash_io_we             = ioWe;
  assign flash_io_out            = ioOut;
  assign qspi.qspi_readData      = readData;
  assign qspi.qspi_readDataValid = readDataValid;
  assign qspi.qspi_initialised   = initialised;
  assign qspi.qspi_busy          = !initialised || !csb || pending;

  assign startAddr = qspi.qspi_changeAddress ? qspi.qspi_address : pendAddr;

  // Bytes arrive MSB-first but fill the word little-endian: byte k lands in [8k+7:8k].
`ifdef FLASH_QSPI_QUAD_EN
  always_comb begin
    rxNext = rxWord;
    rxNext[{bitCnt[2:1], ~bitCnt[0], 2'b00} +: 4] = flash_io_in;
  end
`else
  logic unusedIoIn;
  assign unusedIoIn = ^{flash_io_in[3:2], flash_io_in[0]};

  always_comb begin
    rxNext = rxWord;
    rxNext[{bitCnt[4:3], ~bitCnt[2:0]}] = flash_io_in[1];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RESET_WAIT;
      phase         <= 1'b0;
      bitCnt        <= '0;
      waitCnt       <= '0;
      txShift       <= '0;
      rxWord        <= '0;
      pending       <= 1'b0;
      pendAddr      <= '0;
      csb           <= 1'b1;
      sck           <= 1'b0;
      ioWe          <= 4'b0001;
      ioOut         <= '0;
      readData      <= '0;
      readDataValid <= 1'b0;
      initialised   <= 1'b0;
    end else begin
      readDataValid <= 1'b0;
      if (!initialised && qspi.qspi_changeAddress) begin
        pending  <= 1'b1;
        pendAddr <= qspi.qspi_address;
      end

      if (initialised && !qspi.qspi_enable) begin
        state   <= IDLE;
        csb     <= 1'b1;
        sck     <= 1'b0;
        phase   <= 1'b0;
        ioWe    <= 4'b0001;
        ioOut   <= '0;
        pending <= 1'b0;
      end else if (initialised && state != IDLE && qspi.qspi_changeAddress) begin
        // Abort: one idle cycle with csb high, then IDLE restarts from the pending address.
        state    <= IDLE;
        csb      <= 1'b1;
        sck      <= 1'b0;
        phase    <= 1'b0;
        ioWe     <= 4'b0001;
        ioOut    <= '0;
        pending  <= 1'b1;
        pendAddr <= qspi.qspi_address;
      end else begin
        case (state)
          RESET_WAIT: begin
            if (waitCnt == 16'(INIT_DELAY - 1)) begin
              state   <= INIT_CMD;
              csb     <= 1'b0;
              sck     <= 1'b0;
              phase   <= 1'b0;
              bitCnt  <= '0;
              ioOut   <= {3'b000, RELEASE_CMD[7]};
              txShift <= {RELEASE_CMD[6:0], 25'd0};
            end else begin
              waitCnt <= waitCnt + 16'd1;
            end
          end

          INIT_CMD, CMD, ADDR: begin
            if (!phase) begin
              sck   <= 1'b1;
              phase <= 1'b1;
            end else begin
              sck   <= 1'b0;
              phase <= 1'b0;
              if (state == INIT_CMD && bitCnt == 6'd7) begin
                state   <= INIT_WAIT;
                csb     <= 1'b1;
                ioOut   <= '0;
                waitCnt <= '0;
              end else if (state == ADDR && bitCnt == 6'd23) begin
                bitCnt <= '0;
                ioOut  <= '0;
                ioWe   <= DATA_WE;
`ifdef FLASH_QSPI_QUAD_EN
                state  <= DUMMY;
`else
                state  <= DATA;
`endif
              end else begin
                ioOut   <= {3'b000, txShift[31]};
                txShift <= {txShift[30:0], 1'b0};
                if (state == CMD && bitCnt == 6'd7) begin
                  bitCnt <= '0;
                  state  <= ADDR;
                end else begin
                  bitCnt <= bitCnt + 6'd1;
                end
              end
            end
          end

          INIT_WAIT: begin
            if (waitCnt == 16'(RESUME_DELAY)) begin
              initialised <= 1'b1;
              state       <= IDLE;
            end else begin
              waitCnt <= waitCnt + 16'd1;
            end
          end

          IDLE: begin
            if (qspi.qspi_enable && (qspi.qspi_changeAddress || pending)) begin
              state   <= CMD;
              csb     <= 1'b0;
              sck     <= 1'b0;
              phase   <= 1'b0;
              bitCnt  <= '0;
              pending <= 1'b0;
              ioWe    <= 4'b0001;
              ioOut   <= {3'b000, READ_CMD[7]};
              txShift <= {READ_CMD[6:0], startAddr, 1'b0};
            end
          end

          DUMMY: begin
            if (!phase) begin
              sck   <= 1'b1;
              phase <= 1'b1;
            end else begin
              sck   <= 1'b0;
              phase <= 1'b0;
              if (bitCnt == 6'd7) begin
                bitCnt <= '0;
                state  <= DATA;
              end else begin
                bitCnt <= bitCnt + 6'd1;
              end
            end
          end

          DATA: begin
            if (!phase) begin
              sck   <= 1'b1;
              phase <= 1'b1;
            end else begin
              sck    <= 1'b0;
              phase  <= 1'b0;
              rxWord <= rxNext;
              if (bitCnt == LAST_DATA) begin
                readData      <= rxNext;
                readDataValid <= 1'b1;
                bitCnt        <= '0;
                if (!qspi.qspi_requestData) state <= PAUSE;
              end else begin
                bitCnt <= bitCnt + 6'd1;
              end
            end
          end

          PAUSE: begin
            if (qspi.qspi_requestData) state <= DATA;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
